// File: rtl/ram_copy_engine.sv
// rtl/ram_copy_engine.sv - copy/fill DMA initiator for a synchronous-read RAM
module ram_copy_engine #(
  parameter int AW = 3,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          mode,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW:0]   len,
  input  logic [DW-1:0] fill_val,
  output logic          busy,
  output logic          done,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [AW-1:0] mem_raddr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WR   = 3'd2,
    FILL = 3'd3,
    FIN  = 3'd4
  } state_t;

  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   REM_ONE = (AW+1)'(1);
  localparam logic [AW:0]   FULL    = (AW+1)'(1) << AW;

  state_t        state, state_nxt;
  logic [AW-1:0] rptr, wptr;
  logic [AW:0]   rem;
  logic          desc_q;
  logic [DW-1:0] fill_q;

  // Command decode: clamp the count, pick the copy direction, find the
  // descending start offsets. Only meaningful while idle with start high.
  logic [AW:0]   len_clamped;
  logic [AW-1:0] len_m1;
  logic [AW-1:0] gap;
  logic          go_desc;
  logic          last;

  assign len_clamped = (len > FULL) ? FULL : len;
  // For a full-RAM count the low bits are zero and wrap to depth-1.
  assign len_m1      = len_clamped[AW-1:0] - PTR_ONE;
  assign gap         = dst - src;
  // Destination lies inside the source window ahead of src: walk backwards
  // so source bytes are read before they are overwritten.
  assign go_desc     = !mode && (dst != src) && ({1'b0, gap} < len_clamped);
  assign last        = (rem == REM_ONE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (len_clamped == '0) state_nxt = FIN;
          else if (mode)         state_nxt = FILL;
          else                   state_nxt = RD;
        end
      end
      RD:      state_nxt = WR;
      WR:      state_nxt = last ? FIN : RD;
      FILL:    state_nxt = last ? FIN : FILL;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch and pointer/count datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr   <= '0;
      wptr   <= '0;
      rem    <= '0;
      desc_q <= 1'b0;
      fill_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            rem    <= len_clamped;
            desc_q <= go_desc;
            fill_q <= fill_val;
            rptr   <= go_desc ? (src + len_m1) : src;
            wptr   <= go_desc ? (dst + len_m1) : dst;
          end
        end
        WR: begin
          rptr <= desc_q ? (rptr - PTR_ONE) : (rptr + PTR_ONE);
          wptr <= desc_q ? (wptr - PTR_ONE) : (wptr + PTR_ONE);
          rem  <= rem - REM_ONE;
        end
        FILL: begin
          wptr <= wptr + PTR_ONE;
          rem  <= rem - REM_ONE;
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs decoded from the registered state; write data in WR is the
  // RAM's registered read data passed straight through.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = wptr;
    mem_raddr = rptr;
    mem_wdata = '0;
    case (state)
      RD: begin
        busy = 1'b1;
      end
      WR: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = mem_rdata;
      end
      FILL: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = fill_q;
      end
      FIN: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_ram_copy_engine.sv
// tb/tb_ram_copy_engine.sv - directed self-checking bench for ram_copy_engine
module tb_ram_copy_engine;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       mode;
  logic [2:0] src;
  logic [2:0] dst;
  logic [3:0] len;
  logic [7:0] fill_val;
  logic       busy;
  logic       done;
  logic       mem_we;
  logic [2:0] mem_waddr;
  logic [2:0] mem_raddr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  int checks;
  int errors;

  logic [7:0] ram [8];
  logic [7:0] pre [8];
  logic [7:0] exp_ram [8];
  logic [2:0] wlog [$];
  int busy_cnt;
  int done_cnt;

  ram_copy_engine #(.AW(3), .DW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .src       (src),
    .dst       (dst),
    .len       (len),
    .fill_val  (fill_val),
    .busy      (busy),
    .done      (done),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_raddr (mem_raddr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 8x8 RAM, registered read, write has priority over read
  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_waddr] <= mem_wdata;
      wlog.push_back(mem_waddr);
    end else begin
      mem_rdata <= ram[mem_raddr];
    end
  end

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (done) done_cnt++;
  end

  task automatic preload();
    pre[0] = 8'h0D; pre[1] = 8'h82; pre[2] = 8'h21; pre[3] = 8'h03;
    pre[4] = 8'h50; pre[5] = 8'h20; pre[6] = 8'h23; pre[7] = 8'hF0;
    for (int i = 0; i < 8; i++) begin
      ram[i]     = pre[i];
      exp_ram[i] = pre[i];
    end
  endtask

  task automatic clear_stats();
    wlog.delete();
    busy_cnt = 0;
    done_cnt = 0;
  endtask

  // Presents a command at a negedge; returns at the negedge after the start edge
  task automatic issue(input logic m, input logic [2:0] s, input logic [2:0] d,
                       input logic [3:0] l, input logic [7:0] f);
    @(negedge clk);
    mode = m; src = s; dst = d; len = l; fill_val = f; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // n = 1 at the negedge just after the start edge
  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0; fill_val = '0;
    preload();
    #12;
    checks++;
    if ({busy, done, mem_we, mem_waddr, mem_raddr, mem_wdata} !== 17'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {busy, done, mem_we, mem_waddr, mem_raddr, mem_wdata});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_copy();
    int n;
    preload();
    clear_stats();
    issue(1'b0, 3'd0, 3'd4, 4'd2, 8'h00);
    wait_done(n);
    exp_ram[4] = 8'h0D; exp_ram[5] = 8'h82;
    checks++;
    if (n !== 5) begin errors++; $display("FAIL copy_latency: got %0d expected 5", n); end
    checks++;
    if (busy_cnt !== 4) begin errors++; $display("FAIL copy_busy_cycles: got %0d expected 4", busy_cnt); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL copy_done_pulses: got %0d expected 1", done_cnt); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ram[i] !== exp_ram[i]) begin
        errors++; $display("FAIL copy_ram[%0d]: got %h expected %h", i, ram[i], exp_ram[i]);
      end
    end
  endtask

  task automatic test_fill_wrap();
    int n;
    logic [2:0] order [4];
    order[0] = 3'd6; order[1] = 3'd7; order[2] = 3'd0; order[3] = 3'd1;
    clear_stats();
    issue(1'b1, 3'd0, 3'd6, 4'd4, 8'hAA);
    wait_done(n);
    exp_ram[6] = 8'hAA; exp_ram[7] = 8'hAA; exp_ram[0] = 8'hAA; exp_ram[1] = 8'hAA;
    checks++;
    if (n !== 5) begin errors++; $display("FAIL fill_latency: got %0d expected 5", n); end
    checks++;
    if (wlog.size() !== 4) begin
      errors++; $display("FAIL fill_write_count: got %0d expected 4", wlog.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wlog[i] !== order[i]) begin
          errors++; $display("FAIL fill_order[%0d]: got %0d expected %0d", i, wlog[i], order[i]);
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ram[i] !== exp_ram[i]) begin
        errors++; $display("FAIL fill_ram[%0d]: got %h expected %h", i, ram[i], exp_ram[i]);
      end
    end
  endtask

  task automatic test_overlap();
    int n;
    logic [2:0] order [4];
    order[0] = 3'd4; order[1] = 3'd3; order[2] = 3'd2; order[3] = 3'd1;
    preload();
    clear_stats();
    issue(1'b0, 3'd0, 3'd1, 4'd4, 8'h00);
    wait_done(n);
    exp_ram[1] = 8'h0D; exp_ram[2] = 8'h82; exp_ram[3] = 8'h21; exp_ram[4] = 8'h03;
    checks++;
    if (n !== 9) begin errors++; $display("FAIL overlap_latency: got %0d expected 9", n); end
    checks++;
    if (wlog.size() !== 4) begin
      errors++; $display("FAIL overlap_write_count: got %0d expected 4", wlog.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wlog[i] !== order[i]) begin
          errors++; $display("FAIL overlap_order[%0d]: got %0d expected %0d", i, wlog[i], order[i]);
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ram[i] !== exp_ram[i]) begin
        errors++; $display("FAIL overlap_ram[%0d]: got %h expected %h", i, ram[i], exp_ram[i]);
      end
    end
  endtask

  task automatic test_zero_len();
    clear_stats();
    issue(1'b0, 3'd1, 3'd5, 4'd0, 8'h00);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL zero_done_first: got %b expected 1", done); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b expected 0", busy); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL zero_done_second: got %b expected 0", done); end
    repeat (3) @(negedge clk);
    checks++;
    if (wlog.size() !== 0) begin errors++; $display("FAIL zero_writes: got %0d expected 0", wlog.size()); end
    checks++;
    if (busy_cnt !== 0) begin errors++; $display("FAIL zero_busy_cycles: got %0d expected 0", busy_cnt); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL zero_done_pulses: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_clamp();
    int n;
    logic [2:0] a;
    clear_stats();
    issue(1'b1, 3'd0, 3'd3, 4'd12, 8'h5A);
    wait_done(n);
    checks++;
    if (n !== 9) begin errors++; $display("FAIL clamp_latency: got %0d expected 9", n); end
    checks++;
    if (wlog.size() !== 8) begin
      errors++; $display("FAIL clamp_write_count: got %0d expected 8", wlog.size());
    end else begin
      a = 3'd3;
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (wlog[i] !== a) begin
          errors++; $display("FAIL clamp_order[%0d]: got %0d expected %0d", i, wlog[i], a);
        end
        a = a + 3'd1;
      end
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ram[i] !== 8'h5A) begin
        errors++; $display("FAIL clamp_ram[%0d]: got %h expected 5a", i, ram[i]);
      end
    end
  endtask

  task automatic test_self_copy();
    int n;
    preload();
    clear_stats();
    issue(1'b0, 3'd2, 3'd2, 4'd3, 8'h00);
    wait_done(n);
    checks++;
    if (wlog.size() !== 3) begin
      errors++; $display("FAIL self_write_count: got %0d expected 3", wlog.size());
    end else begin
      checks++;
      if ({wlog[0], wlog[1], wlog[2]} !== {3'd2, 3'd3, 3'd4}) begin
        errors++; $display("FAIL self_order: got %0d %0d %0d expected 2 3 4", wlog[0], wlog[1], wlog[2]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ram[i] !== exp_ram[i]) begin
        errors++; $display("FAIL self_ram[%0d]: got %h expected %h", i, ram[i], exp_ram[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    preload();
    clear_stats();
    issue(1'b0, 3'd0, 3'd4, 4'd2, 8'h00);
    mode = 1'b1; src = 3'd0; dst = 3'd0; len = 4'd8; fill_val = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    repeat (4) @(negedge clk);
    exp_ram[4] = 8'h0D; exp_ram[5] = 8'h82;
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL b2b_done_pulses: got %0d expected 1", done_cnt); end
    checks++;
    if (wlog.size() !== 2) begin errors++; $display("FAIL b2b_write_count: got %0d expected 2", wlog.size()); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ram[i] !== exp_ram[i]) begin
        errors++; $display("FAIL b2b_ram[%0d]: got %h expected %h", i, ram[i], exp_ram[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    preload();
    clear_stats();
    issue(1'b0, 3'd0, 3'd4, 4'd8, 8'h00);
    repeat (3) @(negedge clk);
    checks++;
    if (mem_we !== 1'b1) begin errors++; $display("FAIL midrst_in_wr: got we=%b expected 1", mem_we); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_we, busy} !== 2'b00) begin
      errors++; $display("FAIL midrst_drop: got we,busy=%b%b expected 00", mem_we, busy);
    end
    clear_stats();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    exp_ram[3] = 8'hF0;
    checks++;
    if (wlog.size() !== 0) begin errors++; $display("FAIL midrst_writes: got %0d expected 0", wlog.size()); end
    checks++;
    if (done_cnt !== 0) begin errors++; $display("FAIL midrst_done: got %0d expected 0", done_cnt); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (ram[i] !== exp_ram[i]) begin
        errors++; $display("FAIL midrst_ram[%0d]: got %h expected %h", i, ram[i], exp_ram[i]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    busy_cnt = 0;
    done_cnt = 0;
    mem_rdata = '0;
    test_reset();
    test_copy();
    test_fill_wrap();
    test_overlap();
    test_zero_len();
    test_clamp();
    test_self_copy();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
